// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Execution controller for the MIPS core. All core state is clocked by
// Clock and advances only when cpu_ce_o is 1. This block generates that
// enable from a free-running divider and adds the following features:
//   - run/pause control
//   - single-step
//   - NUM_BP PC breakpoints
//   - an instruction-retire counter
//
// Optional feature macro: CPU_RUN_CTRL_WDOG_EN
//   When it is defined, a same-PC watchdog is built. It forces BREAK after
//   WDOG_N consecutive enables at an unchanged PC. When it is undefined,
//   no watchdog logic is built and wdog_o is tied to 0.
//
// Ports:
//   Clock         system clock
//   Reset         synchronous, active-high reset
//   run_i         level input: 1 = run, 0 = pause
//   step_i        single-step request (rising edge detected here)
//   slow_i        1 = slow tick rate, 0 = fast tick rate
//   pc_i          current core PC
//   bp_addr_i     breakpoint addresses; slot k is [k*PC_W +: PC_W]
//   bp_en_i       per-slot breakpoint enable
//   cpu_ce_o      one-Clock enable; the core retires one instruction
//   state_o       0 PAUSE, 1 RUN, 2 STEP, 3 BREAK
//   halted_o      1 while in BREAK
//   bp_hit_o      breakpoint slots that caused the current BREAK
//   wdog_o        1 when the current BREAK was caused by the watchdog
//   retire_cnt_o  count of cpu_ce_o pulses; wraps silently
//
// state | meaning
// ------+------------------------------------------------------------------
// PAUSE | core frozen; waits for run_i or a step edge
// RUN   | one enable per tick; breakpoints and watchdog are checked
// STEP  | waits for the next tick, issues one enable, returns to PAUSE
// BREAK | halted on a breakpoint or watchdog; drop run_i or step to leave
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int PC_W       = 32,
  parameter int NUM_BP     = 2,
  parameter int CNT_W      = 32,
  parameter int FAST_SHIFT = 2,
  parameter int SLOW_SHIFT = 24,
  parameter int WDOG_N     = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   run_i,
  input  logic                   step_i,
  input  logic                   slow_i,
  input  logic [PC_W-1:0]        pc_i,
  input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]      bp_en_i,
  output logic                   cpu_ce_o,
  output logic [1:0]             state_o,
  output logic                   halted_o,
  output logic [NUM_BP-1:0]      bp_hit_o,
  output logic                   wdog_o,
  output logic [CNT_W-1:0]       retire_cnt_o
);

  localparam logic [1:0] PAUSE = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;
  localparam logic [1:0] BREAK = 2'd3;

  localparam int DIV_W = SLOW_SHIFT;

  // Catch illegal parameter combinations at elaboration time.
  if (NUM_BP < 1 || NUM_BP > 8) begin : gBadNumBp
    $error("cpu_run_ctrl: NUM_BP must be in 1..8");
  end
  if (FAST_SHIFT < 1 || SLOW_SHIFT <= FAST_SHIFT) begin : gBadShift
    $error("cpu_run_ctrl: need 1 <= FAST_SHIFT < SLOW_SHIFT");
  end
  if (WDOG_N < 1) begin : gBadWdog
    $error("cpu_run_ctrl: WDOG_N must be at least 1");
  end

  logic [1:0]        state;
  logic [1:0]        stateNxt;
  logic [DIV_W-1:0]  divCnt;
  logic              tick;
  logic              stepQ;
  logic              stepEdge;
  logic              skip;
  logic [NUM_BP-1:0] bpMatch;
  logic [NUM_BP-1:0] bpHit;
  logic              anyBp;
  logic              bpBreak;
  logic              wdogTrip;
  logic              ceInt;
  logic              enterBreak;
  logic              leaveBreak;
  logic [CNT_W-1:0]  retireCnt;

  // The divider is never realigned. A slow_i change only selects a
  // different compare on the running count.
  assign tick     = slow_i ? (&divCnt) : (&divCnt[FAST_SHIFT-1:0]);
  assign stepEdge = step_i & ~stepQ;

  for (genvar k = 0; k < NUM_BP; k++) begin : gBp
    assign bpMatch[k] = bp_en_i[k] && (pc_i == bp_addr_i[k*PC_W +: PC_W]);
  end

  assign anyBp = |bpMatch;

  // skip masks the breakpoint that was just serviced. This lets the core
  // retire the instruction at that PC once.
  assign bpBreak = anyBp && !skip;

  always_comb begin
    stateNxt   = state;
    ceInt      = 1'b0;
    enterBreak = 1'b0;
    leaveBreak = 1'b0;
    case (state)
      PAUSE: begin
        // run_i wins over a simultaneous step edge; that step is dropped.
        if (run_i) begin
          stateNxt = RUN;
        end else if (stepEdge) begin
          stateNxt = STEP;
        end
      end
      RUN: begin
        if (!run_i) begin
          stateNxt = PAUSE;
        end else if (tick && (bpBreak || wdogTrip)) begin
          stateNxt   = BREAK;
          enterBreak = 1'b1;
        end else if (tick) begin
          ceInt = 1'b1;
        end
      end
      STEP: begin
        if (tick) begin
          ceInt    = 1'b1;
          stateNxt = PAUSE;
        end
      end
      BREAK: begin
        // Holding run_i high keeps BREAK. The operator must drop run_i
        // and raise it again to resume.
        if (!run_i) begin
          stateNxt   = PAUSE;
          leaveBreak = 1'b1;
        end else if (stepEdge) begin
          stateNxt   = STEP;
          leaveBreak = 1'b1;
        end
      end
      default: stateNxt = PAUSE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= PAUSE;
      divCnt    <= '0;
      stepQ     <= 1'b0;
      skip      <= 1'b0;
      bpHit     <= '0;
      retireCnt <= '0;
    end else begin
      state  <= stateNxt;
      divCnt <= divCnt + DIV_W'(1);
      stepQ  <= step_i;

      if (ceInt) begin
        retireCnt <= retireCnt + CNT_W'(1);
      end

      if (leaveBreak) begin
        skip <= 1'b1;
      end else if (ceInt) begin
        skip <= 1'b0;
      end

      // A BREAK caused only by the watchdog reports no breakpoint slots.
      if (enterBreak) begin
        bpHit <= bpBreak ? bpMatch : '0;
      end else if (leaveBreak) begin
        bpHit <= '0;
      end
    end
  end

`ifdef CPU_RUN_CTRL_WDOG_EN
  localparam int              WD_W     = $clog2(WDOG_N + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_N);

  logic [PC_W-1:0] lastPc;
  logic            lastPcVld;
  logic [WD_W-1:0] sameCnt;
  logic            samePc;
  logic            wdogFlag;

  // sameCnt counts consecutive enables at an unchanged PC. A PC change
  // fails samePc, so the next enable restarts the count at 1.
  assign samePc   = lastPcVld && (pc_i == lastPc);
  assign wdogTrip = samePc && (sameCnt >= WD_LIMIT);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lastPc    <= '0;
      lastPcVld <= 1'b0;
      sameCnt   <= '0;
      wdogFlag  <= 1'b0;
    end else if (leaveBreak) begin
      lastPcVld <= 1'b0;
      sameCnt   <= '0;
      wdogFlag  <= 1'b0;
    end else begin
      if (enterBreak) begin
        wdogFlag <= wdogTrip && !bpBreak;
      end
      if (ceInt) begin
        lastPc    <= pc_i;
        lastPcVld <= 1'b1;
        if (!samePc) begin
          sameCnt <= WD_W'(1);
        end else if (sameCnt != WD_LIMIT) begin
          // Saturate; STEP can still retire at a looping PC.
          sameCnt <= sameCnt + WD_W'(1);
        end
      end
    end
  end

  assign wdog_o = wdogFlag;
`else
  assign wdogTrip = 1'b0;
  assign wdog_o   = 1'b0;
`endif

  // Reset also gates the combinational enable. This prevents a stray pulse
  // during a mid-run reset.
  assign cpu_ce_o     = ceInt & ~Reset;
  assign state_o      = state;
  assign halted_o     = (state == BREAK);
  assign bp_hit_o     = bpHit;
  assign retire_cnt_o = retireCnt;

endmodule
